// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one req/ack memory bus between the fetch port and the data port.
//   clk, rst (async, active-low)
//   if_*  : fetch port in (ce, addr), out (rdata, stallreq)
//   dm_*  : data port in (ce, we, addr, wdata, sel), out (rdata, stallreq)
//   pipe_adv_i : pipeline advanced, releases held results
//   bus_* : registered request side (req, we, addr, wdata, sel, err), response side (ack, rdata)
module mem_bus_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int TIMEOUT = 255,
    parameter logic [DATA_W-1:0] ERR_DATA = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_ce_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_stallreq_o,
    input  logic              dm_ce_i,
    input  logic              dm_we_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    input  logic [3:0]        dm_sel_i,
    output logic [DATA_W-1:0] dm_rdata_o,
    output logic              dm_stallreq_o,
    input  logic              pipe_adv_i,
    output logic              bus_req_o,
    output logic              bus_we_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [DATA_W-1:0] bus_wdata_o,
    output logic [3:0]        bus_sel_o,
    input  logic              bus_ack_i,
    input  logic [DATA_W-1:0] bus_rdata_i,
    output logic              bus_err_o
);
    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM} state_t;
    localparam int CNT_W = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
    state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic hold_if_q, hold_if_d, hold_dm_q, hold_dm_d;
    logic [DATA_W-1:0] buf_if_q, buf_if_d, buf_dm_q, buf_dm_d;
    logic bus_req_q, bus_req_d, bus_we_q, bus_we_d, bus_err_q, bus_err_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
    logic [3:0] bus_sel_q, bus_sel_d;
    logic pend_if, pend_dm, busy, ack, tmo, done, done_if, done_dm, grant_if, grant_dm;
    always_comb begin
        pend_if = if_ce_i & ~hold_if_q;
        pend_dm = dm_ce_i & ~hold_dm_q;
        busy = state_q != IDLE;
        ack = busy & bus_ack_i;
        tmo = busy & ~bus_ack_i & (TIMEOUT != 0) & (cnt_q == CNT_MAX);
        done = ack | tmo;
        done_if = done & (state_q == BUSY_IF);
        done_dm = done & (state_q == BUSY_DM);
        // data side wins ties: it belongs to the older instruction
        grant_dm = (state_q == IDLE) & pend_dm;
        grant_if = (state_q == IDLE) & ~pend_dm & pend_if;
        state_d = done ? IDLE : grant_dm ? BUSY_DM : grant_if ? BUSY_IF : state_q;
        cnt_d = (!busy || done) ? '0 : cnt_q + 1'b1;
        // a completion in the same cycle as pipe_adv_i keeps the new hold
        hold_if_d = done_if | (hold_if_q & ~pipe_adv_i);
        hold_dm_d = done_dm | (hold_dm_q & ~pipe_adv_i);
        buf_if_d = done_if ? (ack ? bus_rdata_i : ERR_DATA) : buf_if_q;
        buf_dm_d = done_dm ? (ack ? bus_rdata_i : ERR_DATA) : buf_dm_q;
        bus_req_d = state_d != IDLE;
        bus_we_d = grant_dm ? dm_we_i : grant_if ? 1'b0 : bus_we_q;
        bus_addr_d = grant_dm ? dm_addr_i : grant_if ? if_addr_i : bus_addr_q;
        bus_wdata_d = grant_dm ? dm_wdata_i : grant_if ? '0 : bus_wdata_q;
        bus_sel_d = grant_dm ? dm_sel_i : grant_if ? 4'hF : bus_sel_q;
        bus_err_d = tmo;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q <= '0;
            hold_if_q <= 1'b0;
            hold_dm_q <= 1'b0;
            buf_if_q <= '0;
            buf_dm_q <= '0;
            bus_req_q <= 1'b0;
            bus_we_q <= 1'b0;
            bus_addr_q <= '0;
            bus_wdata_q <= '0;
            bus_sel_q <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            hold_if_q <= hold_if_d;
            hold_dm_q <= hold_dm_d;
            buf_if_q <= buf_if_d;
            buf_dm_q <= buf_dm_d;
            bus_req_q <= bus_req_d;
            bus_we_q <= bus_we_d;
            bus_addr_q <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_sel_q <= bus_sel_d;
            bus_err_q <= bus_err_d;
        end
    end
    assign if_stallreq_o = pend_if;
    assign dm_stallreq_o = pend_dm;
    assign if_rdata_o = buf_if_q;
    assign dm_rdata_o = buf_dm_q;
    assign bus_req_o = bus_req_q;
    assign bus_we_o = bus_we_q;
    assign bus_addr_o = bus_addr_q;
    assign bus_wdata_o = bus_wdata_q;
    assign bus_sel_o = bus_sel_q;
    assign bus_err_o = bus_err_q;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: vector table plus corner sequences against a scoreboarded bus responder.
module tb_mem_bus_arbiter;
    localparam logic [31:0] ERR = 32'hEEEE0BAD;
    logic clk = 1'b0, rst = 1'b1;
    logic if_ce_i = 0, dm_ce_i = 0, dm_we_i = 0, pipe_adv_i = 0, bus_ack_i = 0;
    logic [31:0] if_addr_i = 0, dm_addr_i = 0, dm_wdata_i = 0, bus_rdata_i = 0;
    logic [3:0] dm_sel_i = 0;
    logic [31:0] if_rdata_o, dm_rdata_o, bus_addr_o, bus_wdata_o;
    logic if_stallreq_o, dm_stallreq_o, bus_req_o, bus_we_o, bus_err_o;
    logic [3:0] bus_sel_o;
    int n_vec = 0, n_bad = 0, err_cnt = 0;
    typedef struct {
        logic we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0] sel;
        int lat;
        logic [31:0] rdata;
    } txn_t;
    typedef struct {
        logic is_dm;
        logic we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0] sel;
        int lat;
        logic [31:0] rdata;
        int exp_stall;
    } vec_t;
    txn_t sb[$];
    txn_t cur;
    logic in_flight = 0;
    int wcnt = 0;
    vec_t vt[7];

    mem_bus_arbiter #(.TIMEOUT(4), .ERR_DATA(ERR)) dut (
        .clk(clk), .rst(rst),
        .if_ce_i(if_ce_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o), .if_stallreq_o(if_stallreq_o),
        .dm_ce_i(dm_ce_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i),
        .dm_sel_i(dm_sel_i), .dm_rdata_o(dm_rdata_o), .dm_stallreq_o(dm_stallreq_o),
        .pipe_adv_i(pipe_adv_i),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o),
        .bus_sel_o(bus_sel_o), .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i), .bus_err_o(bus_err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic we, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] s, input int lat, input logic [31:0] rd);
        sb.push_back('{we, a, wd, s, lat, rd});
    endtask

    // bus slave: pops the expected transaction when a request starts, acks after its latency
    initial forever begin
        @(negedge clk);
        bus_ack_i = 0;
        if (bus_err_o) err_cnt++;
        if (bus_req_o) begin
            if (!in_flight) begin
                in_flight = 1;
                wcnt = 0;
                if (sb.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL bus_unexpected: got addr %0h we %0b expected no transaction", bus_addr_o, bus_we_o);
                    cur = '{bus_we_o, bus_addr_o, bus_wdata_o, bus_sel_o, 1, 32'h0};
                end else cur = sb.pop_front();
                if (cur.we) check("bus_wdata", 64'(bus_wdata_o), 64'(cur.wdata));
            end
            check("bus_we_addr_sel", 64'({bus_we_o, bus_addr_o, bus_sel_o}), 64'({cur.we, cur.addr, cur.sel}));
            wcnt++;
            if (cur.lat != 0 && wcnt == cur.lat) begin
                bus_ack_i = 1;
                bus_rdata_i = cur.rdata;
            end
        end else in_flight = 0;
    end

    task automatic release_ports();
        repeat (2) begin
            @(negedge clk);
            #1;
            check("held_if_stall", 64'(if_stallreq_o), 64'd0);
            check("held_dm_stall", 64'(dm_stallreq_o), 64'd0);
        end
        @(negedge clk);
        pipe_adv_i = 1;
        @(negedge clk);
        pipe_adv_i = 0;
        if_ce_i = 0;
        dm_ce_i = 0;
        dm_we_i = 0;
    endtask

    task automatic access(input vec_t v);
        int n;
        @(negedge clk);
        if (v.is_dm) begin
            dm_ce_i = 1; dm_we_i = v.we; dm_addr_i = v.addr; dm_wdata_i = v.wdata; dm_sel_i = v.sel;
        end else begin
            if_ce_i = 1; if_addr_i = v.addr;
        end
        push(v.we, v.addr, v.wdata, v.sel, v.lat, v.rdata);
        n = 0;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (!(v.is_dm ? dm_stallreq_o : if_stallreq_o)) break;
            n++;
            @(negedge clk);
        end
        check(v.is_dm ? "dm_stall_cycles" : "if_stall_cycles", 64'(n), 64'(v.exp_stall));
        if (!v.we) check(v.is_dm ? "dm_rdata" : "if_rdata", 64'(v.is_dm ? dm_rdata_o : if_rdata_o), 64'(v.rdata));
        release_ports();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, dm_lo, if_lo;
        vt[0] = '{1'b0, 1'b0, 32'h00000010, 32'h0, 4'hF, 1, 32'h3C010001, 2};
        vt[1] = '{1'b1, 1'b0, 32'h00000200, 32'h0, 4'hF, 1, 32'h12345678, 2};
        vt[2] = '{1'b1, 1'b1, 32'h00000100, 32'hDEADBEEF, 4'b0011, 2, 32'h0, 3};
        vt[3] = '{1'b0, 1'b0, 32'h00000024, 32'h0, 4'hF, 3, 32'hCAFEF00D, 4};
        vt[4] = '{1'b1, 1'b0, 32'h00000008, 32'h0, 4'b1000, 2, 32'hA5A55A5A, 3};
        vt[5] = '{1'b0, 1'b0, 32'hFFFFFFFC, 32'h0, 4'hF, 1, 32'hFFFF0000, 2};
        vt[6] = '{1'b1, 1'b1, 32'h00000300, 32'h01020304, 4'hF, 3, 32'h77777777, 4};
        #1 rst = 0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_bus_req", 64'(bus_req_o), 64'd0);
        check("rst_bus_we_sel_err", 64'({bus_we_o, bus_sel_o, bus_err_o}), 64'd0);
        check("rst_bus_addr", 64'(bus_addr_o), 64'd0);
        check("rst_bus_wdata", 64'(bus_wdata_o), 64'd0);
        check("rst_rdata", 64'({if_rdata_o, dm_rdata_o}), 64'd0);
        check("rst_stalls", 64'({if_stallreq_o, dm_stallreq_o}), 64'd0);
        @(negedge clk);
        rst = 1;
        foreach (vt[i]) access(vt[i]);
        // simultaneous requests: data first, then fetch, no repeat of the data access
        @(negedge clk);
        if_ce_i = 1; if_addr_i = 32'h20;
        dm_ce_i = 1; dm_we_i = 0; dm_addr_i = 32'h80; dm_sel_i = 4'hF;
        push(0, 32'h80, 0, 4'hF, 3, 32'hD0D0D0D0);
        push(0, 32'h20, 0, 4'hF, 3, 32'h8C220004);
        dm_lo = -1;
        if_lo = -1;
        for (int c = 0; c < 40 && if_lo < 0; c++) begin
            #1;
            if (dm_lo < 0 && !dm_stallreq_o) dm_lo = c;
            if (!if_stallreq_o) if_lo = c;
            else @(negedge clk);
        end
        check("simul_dm_free_cycle", 64'(dm_lo), 64'd4);
        check("simul_if_free_cycle", 64'(if_lo), 64'd8);
        check("simul_dm_rdata", 64'(dm_rdata_o), 64'hD0D0D0D0);
        check("simul_if_rdata", 64'(if_rdata_o), 64'h8C220004);
        release_ports();
        // hold set/clear collision: data hold released while fetch completes
        @(negedge clk);
        if_ce_i = 1; if_addr_i = 32'h30;
        dm_ce_i = 1; dm_we_i = 0; dm_addr_i = 32'h90; dm_sel_i = 4'hF;
        push(0, 32'h90, 0, 4'hF, 1, 32'h1111AAAA);
        push(0, 32'h30, 0, 4'hF, 2, 32'h2222BBBB);
        repeat (4) @(negedge clk);
        #1;
        check("coll_pre_stalls", 64'({if_stallreq_o, dm_stallreq_o}), 64'b10);
        pipe_adv_i = 1;
        @(negedge clk);
        pipe_adv_i = 0;
        dm_addr_i = 32'h94;
        push(0, 32'h94, 0, 4'hF, 1, 32'h3333CCCC);
        #1;
        check("coll_post_stalls", 64'({if_stallreq_o, dm_stallreq_o}), 64'b01);
        check("coll_if_rdata", 64'(if_rdata_o), 64'h2222BBBB);
        check("coll_dm_rdata", 64'(dm_rdata_o), 64'h1111AAAA);
        repeat (2) @(negedge clk);
        #1;
        check("coll_dm2_stall", 64'(dm_stallreq_o), 64'd0);
        check("coll_dm2_rdata", 64'(dm_rdata_o), 64'h3333CCCC);
        release_ports();
        // timeout on a fetch that is never acknowledged
        @(negedge clk);
        if_ce_i = 1; if_addr_i = 32'h44;
        push(0, 32'h44, 0, 4'hF, 0, 32'h0);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            #1;
            check("tmo_req_err_stall", 64'({bus_req_o, bus_err_o, if_stallreq_o}), 64'b101);
        end
        @(negedge clk);
        #1;
        check("tmo_abort_req_err_stall", 64'({bus_req_o, bus_err_o, if_stallreq_o}), 64'b010);
        check("tmo_if_rdata", 64'(if_rdata_o), 64'(ERR));
        @(negedge clk);
        #1;
        check("tmo_err_single_pulse", 64'(bus_err_o), 64'd0);
        release_ports();
        // reset in the middle of a data transfer
        @(negedge clk);
        dm_ce_i = 1; dm_we_i = 0; dm_addr_i = 32'h40; dm_sel_i = 4'hF;
        push(0, 32'h40, 0, 4'hF, 0, 32'h0);
        repeat (2) begin
            @(negedge clk);
            #1;
            check("rstmid_req_before", 64'(bus_req_o), 64'd1);
        end
        #1 rst = 0;
        #1;
        check("rstmid_req_async_drop", 64'(bus_req_o), 64'd0);
        check("rstmid_bus_addr", 64'(bus_addr_o), 64'd0);
        check("rstmid_dm_stall", 64'(dm_stallreq_o), 64'd1);
        @(negedge clk);
        rst = 1;
        push(0, 32'h40, 0, 4'hF, 2, 32'h44445555);
        n = 0;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (!dm_stallreq_o) break;
            n++;
            @(negedge clk);
        end
        check("rstmid_reissue_stall_cycles", 64'(n), 64'd3);
        check("rstmid_reissue_rdata", 64'(dm_rdata_o), 64'h44445555);
        release_ports();
        repeat (3) @(negedge clk);
        check("sb_empty", 64'(sb.size()), 64'd0);
        check("err_pulse_count", 64'(err_cnt), 64'd1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one external memory bus between two requesters: the instruction-fetch port (pc_reg/if_id side) and the data-memory port (mem stage side).
- The bus has a variable-latency req/ack handshake.
- Per-port stall requests are generated for ctrl. Completed results are held until the pipeline advances, so a port served early does not re-issue while the other port is still pending.
- Instantiated in the CPU top between the core's rom_*/ram_* signals and the SoC bus.

Parameters:
ADDR_W, 32, address width of both ports and the bus
DATA_W, 32, data width
TIMEOUT, 255, max cycles waiting for bus_ack_i before abort; 0 disables the timeout
ERR_DATA, 32'h00000000, read data returned on a timed-out access

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
if_ce_i  in  1  fetch request (held stable while if_stallreq_o=1)
if_addr_i  in  ADDR_W  fetch address
if_rdata_o  out  DATA_W  fetch data (valid when if_ce_i=1 and if_stallreq_o=0)
if_stallreq_o  out  1  fetch stall request to ctrl
dm_ce_i  in  1  data request
dm_we_i  in  1  1=write, 0=read
dm_addr_i  in  ADDR_W  data address
dm_wdata_i  in  DATA_W  write data
dm_sel_i  in  4  byte enables
dm_rdata_o  out  DATA_W  read data
dm_stallreq_o  out  1  data stall request to ctrl
pipe_adv_i  in  1  pipeline advanced this cycle (no stall from ctrl)
bus_req_o  out  1  bus request
bus_we_o  out  1  bus write enable
bus_addr_o  out  ADDR_W  bus address
bus_wdata_o  out  DATA_W  bus write data
bus_sel_o  out  4  bus byte enables
bus_ack_i  in  1  bus completion, one-cycle pulse
bus_rdata_i  in  DATA_W  bus read data, valid with bus_ack_i
bus_err_o  out  1  one-cycle pulse on timeout abort

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - All bus_* outputs are 0. bus_req_o drops immediately, including mid-transfer.
  - hold_if, hold_dm, both data buffers, the timeout counter and bus_err_o are 0.
- States: IDLE, BUSY_IF, BUSY_DM.
- Pending flags: pend_dm = dm_ce_i & ~hold_dm; pend_if = if_ce_i & ~hold_if.
- Stall requests are combinational: if_stallreq_o = pend_if; dm_stallreq_o = pend_dm.
- Read data outputs are combinational: if_rdata_o = buffer_if; dm_rdata_o = buffer_dm.
- IDLE:
  - If pend_dm, go to BUSY_DM. The data request has priority because it belongs to the older instruction.
  - Else if pend_if, go to BUSY_IF.
  - On the transition edge, register bus_req_o=1 and latch bus_addr_o/we/wdata/sel from the granted port. A fetch always drives we=0 and sel=4'hF.
- BUSY_x:
  - Bus outputs stay constant; the counter increments each cycle.
  - On bus_ack_i=1: buffer_x <= bus_rdata_i (a write stores bus_rdata_i, value unspecified), hold_x <= 1, bus_req_o <= 0, counter <= 0, go to IDLE.
  - If TIMEOUT!=0 and the counter reaches TIMEOUT-1 without ack: buffer_x <= ERR_DATA, hold_x <= 1, bus_req_o <= 0, bus_err_o pulses for 1 cycle, go to IDLE.
- Latency: ce asserted at cycle 0 with the bus idle → bus_req_o=1 at cycle 1 → ack at cycle 1 at the earliest → stallreq low at cycle 2. Zero-wait access therefore costs 2 stall cycles.
- IDLE always lasts at least 1 cycle between transfers; no back-to-back grant without it.
- hold_x clears on any cycle with pipe_adv_i=1. If set and clear coincide for the same port, set wins.
- A port with hold_x=1 is never re-granted until pipe_adv_i clears it. This prevents re-fetching or re-writing while the other port is still stalling the pipeline.
- If a requester drops ce while granted, the transfer still completes; the result is buffered and hold is cleared by the next pipe_adv_i.
- The bus transaction in flight is never preempted. A dm request arriving during BUSY_IF waits for completion, then is granted next from IDLE.

Test Plan:
1. Reset mid-transfer: assert dm_ce_i; bus_req_o=1 in BUSY_DM; pull rst low → bus_req_o=0 immediately, dm_stallreq_o=1 after release, new request re-issued from IDLE.
2. Single fetch, zero-wait: if_ce_i=1, if_addr_i=0x00000010, bus acks in the first req cycle with 0x3C010001 → bus_addr_o=0x10, bus_sel_o=4'hF, if_stallreq_o high for exactly 2 cycles, then if_rdata_o=0x3C010001; pipe_adv_i=1 clears hold.
3. Simultaneous requests: if_ce_i=1 (addr 0x20), dm_ce_i=1 read (addr 0x80) at the same cycle, ack latency 3 → dm served first (bus_addr_o=0x80), then fetch (0x20); dm_stallreq_o drops before if_stallreq_o; no second 0x80 access while the fetch is pending.
4. Store: dm_we_i=1, addr 0x100, wdata 0xDEADBEEF, sel 4'b0011 → bus_we_o=1, bus_wdata_o=0xDEADBEEF, bus_sel_o=4'b0011, exactly one bus write even though dm_ce_i stays high until pipe_adv_i.
5. Timeout: TIMEOUT=4, never ack a fetch → bus_req_o high for 4 cycles, then bus_err_o pulses once, if_rdata_o=ERR_DATA, if_stallreq_o=0.
6. Set/clear collision: hold_dm=1 and pipe_adv_i=1 in the same cycle as bus_ack_i for the fetch port → hold_dm clears, hold_if sets.
